cluster_speriph_plug_arb: RTL



---
 rtl/cluster_speriph_plug_arb.sv | 113 +++++++++++
 1 files changed

// File: rtl/cluster_speriph_plug_arb.sv
// cluster_speriph_plug_arb: shares one peripheral slave port between NB_PLUGS plugs with in-order response routing.
// Ports:
//   clk_i, rst_ni                     clock, asynchronous active-low reset
//   s_req_i/s_wen_i/s_add_i/s_wdata_i/s_be_i/s_id_i   per-plug requests
//   s_gnt_o, s_r_valid_o              per-plug grant / response valid (one-hot)
//   s_r_rdata_o, s_r_opc_o, s_r_id_o  response fields broadcast to all plugs
//   m_req_o..m_id_o                   request to the shared peripheral
//   m_gnt_i, m_r_valid_i, m_r_*       peripheral grant / response
//   outstanding_o                     ownership FIFO occupancy
//   rsp_err_o                         sticky: response arrived with no owner
// Define CLUSTER_SPERIPH_ARB_RR_EN for round-robin arbitration; otherwise the lowest index wins.
module cluster_speriph_plug_arb #(
  parameter int NB_PLUGS        = 2,
  parameter int ID_WIDTH        = 5,
  parameter int MAX_OUTSTANDING = 2,
  localparam int PW = $clog2(NB_PLUGS),
  localparam int AW = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1,
  localparam int CW = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [NB_PLUGS-1:0]                s_req_i,
  input  logic [NB_PLUGS-1:0]                s_wen_i,
  input  logic [NB_PLUGS-1:0][31:0]          s_add_i,
  input  logic [NB_PLUGS-1:0][31:0]          s_wdata_i,
  input  logic [NB_PLUGS-1:0][3:0]           s_be_i,
  input  logic [NB_PLUGS-1:0][ID_WIDTH-1:0]  s_id_i,
  output logic [NB_PLUGS-1:0]                s_gnt_o,
  output logic [NB_PLUGS-1:0]                s_r_valid_o,
  output logic [31:0]                        s_r_rdata_o,
  output logic                               s_r_opc_o,
  output logic [ID_WIDTH-1:0]                s_r_id_o,
  output logic                               m_req_o,
  output logic                               m_wen_o,
  output logic [31:0]                        m_add_o,
  output logic [31:0]                        m_wdata_o,
  output logic [3:0]                         m_be_o,
  output logic [ID_WIDTH-1:0]                m_id_o,
  input  logic                               m_gnt_i,
  input  logic                               m_r_valid_i,
  input  logic                               m_r_opc_i,
  input  logic [31:0]                        m_r_rdata_i,
  input  logic [ID_WIDTH-1:0]                m_r_id_i,
  output logic [CW-1:0]                      outstanding_o,
  output logic                               rsp_err_o
);
  logic [PW-1:0] win;
  logic          any_req;
  logic [PW-1:0] fifo_q [MAX_OUTSTANDING];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic          full, empty, push, pop;
`ifdef CLUSTER_SPERIPH_ARB_RR_EN
  logic [PW-1:0] rr_q;
  // Scan offsets from the far end so the closest requester to rr_q is assigned last.
  always_comb begin
    win = '0;
    any_req = 1'b0;
    for (int k = NB_PLUGS - 1; k >= 0; k--) begin
      int j;
      j = (int'(rr_q) + k) % NB_PLUGS;
      if (s_req_i[j]) begin
        win = PW'(j);
        any_req = 1'b1;
      end
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) rr_q <= '0;
    else if (push) rr_q <= (win == PW'(NB_PLUGS - 1)) ? '0 : win + PW'(1);
`else
  always_comb begin
    win = '0;
    any_req = 1'b0;
    for (int k = NB_PLUGS - 1; k >= 0; k--)
      if (s_req_i[k]) begin
        win = PW'(k);
        any_req = 1'b1;
      end
  end
`endif
  assign full  = cnt_q == CW'(MAX_OUTSTANDING);
  assign empty = cnt_q == '0;
  assign pop   = m_r_valid_i & ~empty;
  // A full FIFO can still take a push when the head is popped this cycle.
  assign m_req_o = any_req & (~full | m_r_valid_i);
  assign push    = m_req_o & m_gnt_i;
  assign m_wen_o   = m_req_o & s_wen_i[win];
  assign m_add_o   = m_req_o ? s_add_i[win] : '0;
  assign m_wdata_o = m_req_o ? s_wdata_i[win] : '0;
  assign m_be_o    = m_req_o ? s_be_i[win] : '0;
  assign m_id_o    = m_req_o ? s_id_i[win] : '0;
  assign s_gnt_o     = push ? NB_PLUGS'(1) << win : '0;
  assign s_r_valid_o = pop ? NB_PLUGS'(1) << fifo_q[rd_q] : '0;
  assign s_r_rdata_o = m_r_rdata_i;
  assign s_r_opc_o   = m_r_opc_i;
  assign s_r_id_o    = m_r_id_i;
  assign outstanding_o = cnt_q;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      wr_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      rsp_err_o <= 1'b0;
    end else begin
      if (push) wr_q <= (wr_q == AW'(MAX_OUTSTANDING - 1)) ? '0 : wr_q + AW'(1);
      if (pop) rd_q <= (rd_q == AW'(MAX_OUTSTANDING - 1)) ? '0 : rd_q + AW'(1);
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
      if (m_r_valid_i & empty) rsp_err_o <= 1'b1;
    end
  always_ff @(posedge clk_i)
    if (push) fifo_q[wr_q] <= win;
endmodule
